// File: rtl/snn_pkg.sv
// Shared definitions for the SNN rate decoder: FSM state encoding and default widths.
package snn_pkg;

  localparam int unsigned WIN_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/snn_spike_counter.sv
// One channel of the rate decoder: saturating spike count plus first-spike timestamp.
module snn_spike_counter
  import snn_pkg::*;
#(
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [WIN_W-1:0] k,
  input  logic             spike,
  output logic [CNT_W-1:0] rate,
  output logic [WIN_W-1:0] first,
  output logic             first_vld
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate      <= '0;
      first     <= '0;
      first_vld <= 1'b0;
    end else if (clear) begin
      rate      <= '0;
      first     <= '0;
      first_vld <= 1'b0;
    end else if (sample_en && spike) begin
      if (rate != '1)
        rate <= rate + 1'b1;
      // Only the earliest spike of the window is timestamped.
      if (!first_vld) begin
        first     <= k;
        first_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/snn_rate_decoder.sv
// Windowed spike-rate decoder: counts spikes per channel over a programmable
// window, timestamps the first spike, and holds the result until accepted.
module snn_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIN_W-1:0]        window,
  input  logic [N_CH-1:0]         spike_in,
  output logic                    busy,
  output logic [N_CH*CNT_W-1:0]   rate_out,
  output logic [N_CH*WIN_W-1:0]   first_out,
  output logic [N_CH-1:0]         first_vld,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_t           state;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] k;
  logic             start_ok;
  logic             sample_en;
  logic             last_sample;

  assign start_ok    = (state == IDLE) && start && (window != '0);
  assign sample_en   = (state == COUNT);
  assign last_sample = (k == win_q - 1'b1);
  assign busy        = (state != IDLE);
  assign out_valid   = (state == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      win_q <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            win_q <= window;
            k     <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          // k stops at window-1, so even an all-ones window never wraps it.
          if (last_sample)
            state <= HOLD;
          else
            k <= k + 1'b1;
        end
        HOLD: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    snn_spike_counter #(
      .WIN_W (WIN_W),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_ok),
      .sample_en (sample_en),
      .k         (k),
      .spike     (spike_in[i]),
      .rate      (rate_out[i*CNT_W +: CNT_W]),
      .first     (first_out[i*WIN_W +: WIN_W]),
      .first_vld (first_vld[i])
    );
  end

endmodule

// File: tb/tb_snn_rate_decoder.sv
// Self-checking bench for snn_rate_decoder: directed scenarios plus random traffic
// compared every cycle against a window-history reference model.
module tb_snn_rate_decoder;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned WIN_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned RMAX  = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [WIN_W-1:0]      window;
  logic [N_CH-1:0]       spike_in;
  logic                  busy;
  logic [N_CH*CNT_W-1:0] rate_out;
  logic [N_CH*WIN_W-1:0] first_out;
  logic [N_CH-1:0]       first_vld;
  logic                  out_valid;
  logic                  out_ready;

  snn_rate_decoder #(
    .N_CH  (N_CH),
    .WIN_W (WIN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .window    (window),
    .spike_in  (spike_in),
    .busy      (busy),
    .rate_out  (rate_out),
    .first_out (first_out),
    .first_vld (first_vld),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remembers the accepted start edge and every sample vector seen
  // during the window; outputs are derived from that history.
  int unsigned     cyc = 0;
  bit              m_active = 1'b0;
  bit              m_valid = 1'b0;
  int unsigned     t_start = 0;
  int unsigned     m_w = 0;
  int unsigned     m_ns = 0;
  int unsigned     m_e;
  logic [N_CH-1:0] smp [0:255];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_valid  = 1'b0;
      m_ns     = 0;
    end else begin
      cyc++;
      if (!m_active) begin
        if (start && window != 0) begin
          m_active = 1'b1;
          t_start  = cyc;
          m_w      = window;
          m_ns     = 0;
        end
      end else begin
        m_e = cyc - t_start;
        if (m_e <= m_w) begin
          smp[m_e-1] = spike_in;
          m_ns       = m_e;
        end else if (out_ready) begin
          m_active = 1'b0;
        end
      end
      m_valid = m_active && ((cyc - t_start) >= m_w);
    end
  end

  function automatic logic [N_CH*CNT_W-1:0] exp_rate();
    logic [N_CH*CNT_W-1:0] r = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      int unsigned cnt = 0;
      for (int j = 0; j < m_ns; j++) cnt += smp[j][ch];
      if (cnt > RMAX) cnt = RMAX;
      r[ch*CNT_W +: CNT_W] = cnt[CNT_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [N_CH*WIN_W-1:0] exp_first();
    logic [N_CH*WIN_W-1:0] r = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      for (int j = m_ns - 1; j >= 0; j--)
        if (smp[j][ch]) r[ch*WIN_W +: WIN_W] = j[WIN_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_fvld();
    logic [N_CH-1:0] r = '0;
    for (int ch = 0; ch < N_CH; ch++)
      for (int j = 0; j < m_ns; j++)
        if (smp[j][ch]) r[ch] = 1'b1;
    return r;
  endfunction

  int unsigned n_res = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      busy,      m_active);
      check("out_valid", out_valid, m_valid);
      check("rate_out",  rate_out,  exp_rate());
      check("first_out", first_out, exp_first());
      check("first_vld", first_vld, exp_fvld());
    end
    if (out_valid === 1'b1 && prev_valid !== 1'b1) n_res++;
    prev_valid = out_valid;
  end

  logic [N_CH-1:0] pat [0:255];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pat();
    for (int j = 0; j < 256; j++) pat[j] = '0;
  endtask

  // Start cycle, then w sample cycles driven from pat; optional illegal start at inj_k.
  task automatic start_and_count(input int w, input int inj_k);
    start  = 1'b1;
    window = w[WIN_W-1:0];
    tick();
    start  = 1'b0;
    window = WIN_W'($urandom);
    for (int kk = 0; kk < w; kk++) begin
      spike_in = pat[kk];
      if (kk == inj_k) begin
        start  = 1'b1;
        window = 8'd3;
      end
      if (kk == w - 1) check("valid_before_last", out_valid, 1'b0);
      tick();
      start = 1'b0;
    end
    spike_in = N_CH'($urandom);
    check("valid_after_window", out_valid, 1'b1);
  endtask

  task automatic finish_hold(input int hold, input bit start_at_hs);
    for (int h = 0; h < hold; h++) begin
      spike_in = N_CH'($urandom);
      tick();
    end
    out_ready = 1'b1;
    if (start_at_hs) begin
      start  = 1'b1;
      window = 8'd2;
    end
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("valid_after_hs", out_valid, 1'b0);
    check("busy_after_hs",  busy,      1'b0);
  endtask

  int unsigned res0;

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    window    = '0;
    spike_in  = '0;
    out_ready = 1'b0;
    #2;
    check("rst_busy",  busy,      1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_rate",  rate_out,  '0);
    check("rst_first", first_out, '0);
    check("rst_fvld",  first_vld, '0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // window=4, ch0 spikes on samples 1 and 3; start on first edge after release
    clear_pat();
    pat[1] = 2'b01;
    pat[3] = 2'b01;
    start_and_count(4, -1);
    check("w4_rate",  rate_out,        4'b0010);
    check("w4_first", first_out[7:0],  8'd1);
    check("w4_fvld",  first_vld,       2'b01);
    finish_hold(1, 1'b0);

    // saturation at 3 with both channels spiking every cycle
    for (int j = 0; j < 256; j++) pat[j] = 2'b11;
    start_and_count(6, -1);
    check("sat_rate",  rate_out,  4'b1111);
    check("sat_first", first_out, 16'h0000);
    check("sat_fvld",  first_vld, 2'b11);
    finish_hold(0, 1'b0);

    // long hold with noisy spikes, stability checked every cycle by the model
    for (int j = 0; j < 256; j++) pat[j] = N_CH'($urandom);
    start_and_count(3, -1);
    finish_hold(10, 1'b0);

    // reset mid-window
    for (int j = 0; j < 256; j++) pat[j] = 2'b11;
    start   = 1'b1;
    window  = 8'd8;
    tick();
    start   = 1'b0;
    spike_in = 2'b11;
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy",  busy,      1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_rate",  rate_out,  '0);
    check("mid_rst_fvld",  first_vld, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) tick();
    check("post_rst_valid", out_valid, 1'b0);
    spike_in = '0;

    // ignored starts: window=0, during COUNT, coincident with handshake
    res0   = n_res;
    start  = 1'b1;
    window = 8'd0;
    tick();
    start  = 1'b0;
    check("w0_ignored", busy, 1'b0);
    clear_pat();
    pat[2] = 2'b10;
    start_and_count(5, 2);
    check("ign_rate", rate_out, 4'b0100);
    finish_hold(2, 1'b1);
    repeat (3) tick();
    check("ign_idle", busy, 1'b0);
    check("ign_results", n_res - res0, 1);

    // full-range window, ch1 spikes only on last sample
    clear_pat();
    pat[254] = 2'b10;
    start_and_count(255, -1);
    check("w255_first", first_out[15:8], 8'd254);
    check("w255_rate",  rate_out,        4'b0100);
    check("w255_fvld",  first_vld,       2'b10);
    finish_hold(0, 1'b0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom % 6) == 0;
      window    = (($urandom % 8) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      spike_in  = N_CH'($urandom);
      out_ready = ($urandom % 3) == 0;
      reset     = ($urandom % 400) != 0;
      tick();
    end
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snn_rate_decoder.md
SNN_RATE_DECODER -- requirements
Module: snn_rate_decoder

Interface
REQ-001 Parameter N_CH, default 2, number of spike channels decoded.
REQ-002 Parameter WIN_W, default 8, width of the window length and of first-spike timestamps.
REQ-003 Parameter CNT_W, default 8, width of each per-channel spike count.
REQ-004 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a counting window; honoured only in IDLE.
REQ-007 window  input  WIN_W  number of sample cycles in the window; sampled on the accepted start cycle.
REQ-008 spike_in  input  N_CH  spike outputs of the SNN core; bit i is channel i.
REQ-009 busy  output  1  high in COUNT and HOLD.
REQ-010 rate_out  output  N_CH*CNT_W  per-channel spike counts; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-011 first_out  output  N_CH*WIN_W  per-channel sample index of the first spike; same packing as rate_out.
REQ-012 first_vld  output  N_CH  bit i high when channel i spiked at least once in the window.
REQ-013 out_valid  output  1  result is held stable and valid.
REQ-014 out_ready  input  1  consumer accepts the result.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, COUNT and HOLD.
REQ-016 IDLE: on start=1 with window!=0, latch window, clear all counts, timestamps and first_vld, then go to COUNT; start=1 with window=0 SHALL be ignored.
REQ-017 Sample index k SHALL be 0 on the first cycle in COUNT and increment by 1 each cycle; spike_in on the start cycle itself SHALL NOT be counted.
REQ-018 COUNT: each cycle, rate for channel i SHALL increment by 1 when spike_in[i]=1 and SHALL saturate at 2^CNT_W-1.
REQ-019 COUNT: on the first cycle with spike_in[i]=1, first_out[i] SHALL load k and first_vld[i] SHALL set; later spikes SHALL NOT change them.
REQ-020 COUNT: on the cycle where k = latched window-1, the last sample SHALL be taken and the FSM SHALL go to HOLD, so out_valid rises exactly window+1 cycles after the accepted start.
REQ-021 start during COUNT or HOLD SHALL be ignored.
REQ-022 HOLD: out_valid=1 and all result outputs SHALL remain stable until out_valid & out_ready; spike_in SHALL be ignored.
REQ-023 On the out_valid & out_ready cycle the FSM SHALL return to IDLE, with out_valid=0 on the next cycle; results SHALL persist in IDLE until the next accepted start.
REQ-024 A start and a handshake in the same cycle SHALL complete only the handshake; start SHALL be re-issued from IDLE.
REQ-025 out_ready outside HOLD SHALL have no effect.
REQ-026 window=2^WIN_W-1 SHALL yield 2^WIN_W-1 samples with no wrap of k.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, busy=0, out_valid=0, rate_out=0, first_out=0, first_vld=0 and the latched window=0, regardless of clk.
REQ-028 Reset asserted mid-COUNT or mid-HOLD SHALL discard the partial result; no out_valid SHALL follow deassertion without a new start.
REQ-029 After reset deassertion the block SHALL accept a start on the first rising edge.

Structure
REQ-030 The state enum (IDLE, COUNT, HOLD) and default WIN_W/CNT_W constants SHALL live in the shared package snn_pkg.
REQ-031 The saturating per-channel counter plus first-spike capture SHALL be the sub-module snn_spike_counter, instantiated N_CH times from a generate loop; the FSM and window counter SHALL stay in snn_rate_decoder.

Verification
REQ-032 window=4, spike_in[0]=1 on samples 1 and 3, ch1 silent -> out_valid at start+5 cycles; rate ch0=2, first_out ch0=1, first_vld=2'b01, rate ch1=0.
REQ-033 CNT_W=2, window=6, spike_in=2'b11 every cycle -> rates saturate at 3 on both channels, first_out=0 on both, first_vld=2'b11.
REQ-034 window=3, out_ready held low 10 cycles after out_valid -> outputs stable for all 10 cycles; ready=1 -> out_valid=0 next cycle, busy=0.
REQ-035 reset pulsed low at sample 2 of a window=8 run with spikes present -> all outputs 0 immediately, no out_valid after release until a new start.
REQ-036 start with window=0, then start during COUNT, then start coincident with the handshake -> all three ignored; exactly one result produced.
REQ-037 window=255, ch1 spikes only on sample 254 -> first_out ch1=254, rate ch1=1, out_valid at start+256 cycles.
